// File: rtl/spi_transmitter_if.sv
// Byte-producer handshake bundle for spi_transmitter.
//   i_data  : byte offered by the producer
//   i_valid : i_data is valid; held with i_data until accepted
//   o_ready : transmitter FIFO has room; a byte moves on any rising
//             clock edge where i_valid && o_ready
// master = producer side, slave = transmitter side.
interface spi_transmitter_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/spi_transmitter.sv
// SPI controller-side byte transmitter (CPOL=0, CPHA=0, LSB first).
// Bytes arrive over a valid/ready handshake into a small circular FIFO.
// Each byte is sent as its own frame: o_select low, CLK_DIV setup cycles,
// then 8 bit periods of CLK_DIV high + CLK_DIV low on o_sclk, followed by
// GAP_CYCLES cycles with o_select high before the next byte is popped.
// Ports:
//   i_clock     : system clock, rising edge
//   i_reset_n   : asynchronous active-low reset
//   bus         : producer handshake (i_data, i_valid, o_ready)
//   o_sclk      : serial clock, idle low
//   o_dataOut   : serial data, changes on o_sclk falling edges
//   o_select    : active-low frame select
//   o_busy      : frame/gap in progress or FIFO non-empty
//   o_fifoCount : bytes currently buffered
module spi_transmitter #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    spi_transmitter_if.slave            bus,
    output logic                        o_sclk,
    output logic                        o_dataOut,
    output logic                        o_select,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifoCount
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;      // shared divider / gap counter
    logic [2:0]         bit_q, bit_d;
    logic               phase_q, phase_d;  // 0: sclk high half, 1: low half
    logic [7:0]         shreg_q, shreg_d;
    logic               sclk_q, sclk_d;
    logic               dout_q, dout_d;
    logic               sel_q, sel_d;
    logic               busy_q, busy_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic push;
    logic pop;

    assign bus.o_ready = (count_q < DEPTH_C);
    assign push        = bus.i_valid && bus.o_ready;

    // Frame sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        dout_d  = dout_q;
        sel_d   = sel_q;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                sel_d  = 1'b1;
                if (count_q != '0) begin
                    // Head byte is loaded and bit 0 presented in the same
                    // edge that drops select, so setup starts immediately.
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    dout_d  = mem_q[rd_ptr_q][0];
                    sel_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        // Falling edge: advance to the next bit. After the
                        // last bit a zero shifts in, which is harmless.
                        sclk_d  = 1'b0;
                        phase_d = 1'b1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        dout_d  = shreg_q[1];
                    end else if (bit_q == 3'd7) begin
                        sel_d   = 1'b1;
                        dout_d  = 1'b0;
                        state_d = GAP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        sclk_d  = 1'b1;
                        phase_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Registered busy reflects the post-edge state and count.
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    // Control registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            sclk_q   <= 1'b0;
            dout_q   <= 1'b0;
            sel_q    <= 1'b1;
            busy_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            sclk_q   <= sclk_d;
            dout_q   <= dout_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Data storage; contents are only read once a valid pointer reaches them.
    always_ff @(posedge i_clock) begin
        if (push) mem_q[wr_ptr_q] <= bus.i_data;
        shreg_q <= shreg_d;
    end

    assign o_sclk      = sclk_q;
    assign o_dataOut   = dout_q;
    assign o_select    = sel_q;
    assign o_busy      = busy_q;
    assign o_fifoCount = count_q;

endmodule

// File: tb/tb_spi_transmitter.sv
// Bench for spi_transmitter: two instances (CLK_DIV=2/GAP=2/DEPTH=4 and
// CLK_DIV=3/GAP=1/DEPTH=2). Accepted bytes are queued as expected frames;
// negedge monitors decode the serial line like a receiver and check frame
// timing, FIFO occupancy, ready and busy against a simple occupancy model.
module tb_spi_transmitter;

    localparam int CD_A = 2, G_A = 2, D_A = 4;
    localparam int CD_B = 3, G_B = 1, D_B = 2;

    logic clk;
    logic rst_n;

    spi_transmitter_if bus_a ();
    spi_transmitter_if bus_b ();

    logic       sclk_a, dout_a, sel_a, busy_a;
    logic [2:0] cnt_a;
    logic       sclk_b, dout_b, sel_b, busy_b;
    logic [1:0] cnt_b;

    spi_transmitter #(.CLK_DIV(CD_A), .FIFO_DEPTH(D_A), .GAP_CYCLES(G_A)) dut_a (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus_a),
        .o_sclk(sclk_a), .o_dataOut(dout_a), .o_select(sel_a),
        .o_busy(busy_a), .o_fifoCount(cnt_a)
    );

    spi_transmitter #(.CLK_DIV(CD_B), .FIFO_DEPTH(D_B), .GAP_CYCLES(G_B)) dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus_b),
        .o_sclk(sclk_b), .o_dataOut(dout_b), .o_select(sel_b),
        .o_busy(busy_b), .o_fifoCount(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         starts_a[$];

    int a_acc, a_started, a_len, a_bits, a_hi, a_lo, a_gap;
    int b_acc, b_started, b_len, b_bits, b_hi, b_lo, b_gap;
    logic [7:0] a_rx, b_rx;
    logic a_psclk, a_psel, b_psclk, b_psel;
    logic saw_nr_a;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Acceptance: a byte is owed a frame whenever valid&&ready at an edge.
    initial forever begin
        @(posedge clk);
        if (rst_n && bus_a.i_valid && bus_a.o_ready) begin
            a_acc++;
            exp_a.push_back(bus_a.i_data);
        end
        if (rst_n && bus_b.i_valid && bus_b.o_ready) begin
            b_acc++;
            exp_b.push_back(bus_b.i_data);
        end
    end

    // Monitor A
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            a_acc = 0; a_started = 0; a_len = 0; a_bits = 0; a_hi = 0; a_lo = 0;
            a_gap = 0; a_psclk = 1'b0; a_psel = 1'b1; a_rx = '0;
        end else begin
            if (!sel_a && a_psel) begin
                a_len = 1; a_bits = 0; a_hi = 0; a_lo = 1; a_rx = '0;
                a_started++;
                starts_a.push_back(cyc);
            end else if (!sel_a) begin
                a_len++;
                if (sclk_a && !a_psclk) begin
                    chk("a_low_before_rise", a_lo, CD_A);
                    if (a_bits < 8) a_rx[a_bits] = dout_a;
                    a_bits++;
                    a_hi = 1;
                end else if (sclk_a) begin
                    a_hi++;
                end else if (a_psclk) begin
                    chk("a_high_phase", a_hi, CD_A);
                    a_lo = 1;
                end else begin
                    a_lo++;
                end
            end else if (!a_psel) begin
                chk("a_select_low_len", a_len, 17 * CD_A);
                chk("a_last_low_phase", a_lo, CD_A);
                chk("a_rising_edges", a_bits, 8);
                if (exp_a.size() == 0) chk("a_unexpected_frame", 0, 1);
                else chk("a_byte", a_rx, exp_a.pop_front());
                a_gap = G_A;
            end
            if (sel_a) chk("a_sclk_idle", sclk_a, 0);
            chk("a_fifo_count", cnt_a, a_acc - a_started);
            chk("a_ready", bus_a.o_ready, (a_acc - a_started) < D_A);
            chk("a_busy", busy_a, (!sel_a || (a_acc != a_started) || (a_gap > 0)));
            if (a_gap > 0) a_gap--;
            a_psel  = sel_a;
            a_psclk = sclk_a;
        end
    end

    // Monitor B
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            b_acc = 0; b_started = 0; b_len = 0; b_bits = 0; b_hi = 0; b_lo = 0;
            b_gap = 0; b_psclk = 1'b0; b_psel = 1'b1; b_rx = '0;
        end else begin
            if (!sel_b && b_psel) begin
                b_len = 1; b_bits = 0; b_hi = 0; b_lo = 1; b_rx = '0;
                b_started++;
            end else if (!sel_b) begin
                b_len++;
                if (sclk_b && !b_psclk) begin
                    chk("b_low_before_rise", b_lo, CD_B);
                    if (b_bits < 8) b_rx[b_bits] = dout_b;
                    b_bits++;
                    b_hi = 1;
                end else if (sclk_b) begin
                    b_hi++;
                end else if (b_psclk) begin
                    chk("b_high_phase", b_hi, CD_B);
                    b_lo = 1;
                end else begin
                    b_lo++;
                end
            end else if (!b_psel) begin
                chk("b_select_low_len", b_len, 17 * CD_B);
                chk("b_rising_edges", b_bits, 8);
                if (exp_b.size() == 0) chk("b_unexpected_frame", 0, 1);
                else chk("b_byte", b_rx, exp_b.pop_front());
                b_gap = G_B;
            end
            if (sel_b) chk("b_sclk_idle", sclk_b, 0);
            chk("b_fifo_count", cnt_b, b_acc - b_started);
            chk("b_busy", busy_b, (!sel_b || (b_acc != b_started) || (b_gap > 0)));
            if (b_gap > 0) b_gap--;
            b_psel  = sel_b;
            b_psclk = sclk_b;
        end
    end

    // Producers: called at a negedge, return at the negedge after acceptance.
    task automatic send_a(input logic [7:0] b);
        int n = 0;
        logic ok;
        bus_a.i_valid = 1'b1;
        bus_a.i_data  = b;
        do begin
            ok = bus_a.o_ready;
            if (!ok) saw_nr_a = 1'b1;
            @(negedge clk);
            n++;
        end while (!ok && n < 500);
        if (!ok) chk("a_send_timeout", 0, 1);
        bus_a.i_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        int n = 0;
        logic ok;
        bus_b.i_valid = 1'b1;
        bus_b.i_data  = b;
        do begin
            ok = bus_b.o_ready;
            @(negedge clk);
            n++;
        end while (!ok && n < 500);
        if (!ok) chk("b_send_timeout", 0, 1);
        bus_b.i_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input int maxc);
        int n = 0;
        while ((busy_a || exp_a.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("a_idle_within_budget", n < maxc, 1);
    endtask

    task automatic wait_idle_b(input int maxc);
        int n = 0;
        while ((busy_b || exp_b.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("b_idle_within_budget", n < maxc, 1);
    endtask

    initial begin
        bus_a.i_valid = 1'b0; bus_a.i_data = '0;
        bus_b.i_valid = 1'b0; bus_b.i_data = '0;
        saw_nr_a = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_dout", dout_a, 0);
        chk("rst_select", sel_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_b_select", sel_b, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bus_a.o_ready, 1);

        fork
            begin
                // Back-to-back frames: starts must be 17*CD+GAP+1 apart.
                starts_a.delete();
                send_a(8'hA5); send_a(8'h3C); send_a(8'hFF); send_a(8'h00);
                wait_idle_a(400);
                chk("a_frame_total", starts_a.size(), 4);
                for (int i = 1; i < starts_a.size(); i++)
                    chk("a_frame_spacing", starts_a[i] - starts_a[i-1], 17 * CD_A + G_A + 1);

                // Burst beyond FIFO capacity: ready must drop, nothing lost.
                saw_nr_a = 1'b0;
                for (int i = 0; i < 6; i++) send_a(8'($urandom_range(0, 255)));
                chk("a_ready_dropped_when_full", saw_nr_a, 1);
                wait_idle_a(600);

                // Randomly spaced traffic.
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 40)) @(negedge clk);
                    send_a(8'($urandom_range(0, 255)));
                end
                wait_idle_a(1500);
            end
            begin
                send_b(8'h11);
                send_b(8'h80);
                for (int i = 0; i < 6; i++) begin
                    repeat ($urandom_range(0, 60)) @(negedge clk);
                    send_b(8'($urandom_range(0, 255)));
                end
                wait_idle_b(1500);
            end
        join

        // Reset in the middle of a frame with bytes still queued.
        send_a(8'hC3); send_a(8'h11); send_a(8'h22);
        begin
            int n = 0;
            while (a_bits < 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("a_reached_bit3", n < 200, 1);
        end
        chk("a_count_before_reset", cnt_a, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_select", sel_a, 1);
        chk("async_rst_sclk", sclk_a, 0);
        chk("async_rst_count", cnt_a, 0);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_dout", dout_a, 0);
        exp_a.delete();
        exp_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_a(8'h5A);
        wait_idle_a(300);
        chk("a_all_delivered", exp_a.size(), 0);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
